// File: rtl/hazard_ctrl_pkg.sv
// Shared types and default latencies for the pipeline hazard controller.
package common;
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam int MUL_CYCLES_DEF = 2;
    localparam int DIV_CYCLES_DEF = 33;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else if (clr)
            count_q <= '0;
        else if (inc && (count_q != '1))
            count_q <= count_q + W'(1);
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Decode-side hazard controller: load-use bubbles, MUL/DIV issue hold with a
// latency FSM, wrong-path flush on taken transfers, and stall/flush perf counters.
module hazard_ctrl
    import common::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rf_p0_addr,
    input  logic [4:0]       id_rf_p1_addr,
    input  logic             id_rf_re0,
    input  logic             id_rf_re1,
    input  logic [4:0]       ex_rf_dst_addr,
    input  logic             ex_rf_we,
    input  logic             ex_dm_re,
    input  logic             ex_mul_div,
    input  logic             ex_div,
    input  logic             ex_take,
    input  logic             perf_clr,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int MAX_LAT = max_int(MUL_CYCLES, DIV_CYCLES);
    localparam int CW      = max_int($clog2(MAX_LAT + 1), 6);

    md_state_t     state_q;
    logic [CW-1:0] md_cnt_q;
    logic [CW-1:0] lat;
    logic          lu;
    logic          mds;
    logic          hold;

    assign lat = ex_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);

    assign lu = ex_dm_re && ex_rf_we && (ex_rf_dst_addr != 5'd0) &&
                ((id_rf_re0 && (id_rf_p0_addr == ex_rf_dst_addr)) ||
                 (id_rf_re1 && (id_rf_p1_addr == ex_rf_dst_addr)));

    // Single-cycle ops (LAT==1) complete in EX without touching the FSM.
    assign mds = (state_q == IDLE) && ex_mul_div && (lat > CW'(1));

    always_comb begin
        hold        = 1'b0;
        if_id_flush = 1'b0;
        id_ex_stall = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_take) begin
                    if_id_flush = 1'b1;
                    id_ex_stall = 1'b1;
                end else if (mds || lu) begin
                    hold        = 1'b1;
                    id_ex_stall = 1'b1;
                end
            end
            BUSY: begin
                // EX holds bubbles while busy, so ex_* fields are don't-care here.
                md_busy = 1'b1;
                if (md_cnt_q > CW'(1)) begin
                    hold        = 1'b1;
                    id_ex_stall = 1'b1;
                end else begin
                    md_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign pc_hold    = hold;
    assign if_id_hold = hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            md_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!ex_take && mds) begin
                        state_q  <= BUSY;
                        md_cnt_q <= lat - CW'(1);
                    end
                end
                BUSY: begin
                    if (md_cnt_q > CW'(1)) begin
                        md_cnt_q <= md_cnt_q - CW'(1);
                    end else begin
                        state_q  <= IDLE;
                        md_cnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr),
        .inc   (pc_hold),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (perf_clr),
        .inc   (if_id_flush),
        .count (flush_cnt)
    );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (default latencies/32-bit counters and
// MUL=1/DIV=3/4-bit counters) checked against an absolute-cycle reference model.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rf_p0_addr = '0, id_rf_p1_addr = '0, ex_rf_dst_addr = '0;
    logic       id_rf_re0 = 0, id_rf_re1 = 0, ex_rf_we = 0, ex_dm_re = 0;
    logic       ex_mul_div = 0, ex_div = 0, ex_take = 0, perf_clr = 0;

    logic        a_pch, a_ifh, a_ifl, a_stl, a_bsy, a_dne;
    logic [31:0] a_scnt, a_fcnt;
    logic        b_pch, b_ifh, b_ifl, b_stl, b_bsy, b_dne;
    logic [3:0]  b_scnt, b_fcnt;

    always #5 clk = ~clk;

    hazard_ctrl u_a (
        .clk(clk), .rst_n(rst_n),
        .id_rf_p0_addr(id_rf_p0_addr), .id_rf_p1_addr(id_rf_p1_addr),
        .id_rf_re0(id_rf_re0), .id_rf_re1(id_rf_re1),
        .ex_rf_dst_addr(ex_rf_dst_addr), .ex_rf_we(ex_rf_we), .ex_dm_re(ex_dm_re),
        .ex_mul_div(ex_mul_div), .ex_div(ex_div), .ex_take(ex_take), .perf_clr(perf_clr),
        .pc_hold(a_pch), .if_id_hold(a_ifh), .if_id_flush(a_ifl), .id_ex_stall(a_stl),
        .md_busy(a_bsy), .md_done(a_dne), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
    );

    hazard_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(3), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .id_rf_p0_addr(id_rf_p0_addr), .id_rf_p1_addr(id_rf_p1_addr),
        .id_rf_re0(id_rf_re0), .id_rf_re1(id_rf_re1),
        .ex_rf_dst_addr(ex_rf_dst_addr), .ex_rf_we(ex_rf_we), .ex_dm_re(ex_dm_re),
        .ex_mul_div(ex_mul_div), .ex_div(ex_div), .ex_take(ex_take), .perf_clr(perf_clr),
        .pc_hold(b_pch), .if_id_hold(b_ifh), .if_id_flush(b_ifl), .id_ex_stall(b_stl),
        .md_busy(b_bsy), .md_done(b_dne), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
    );

    int n_chk = 0, n_err = 0;

    // Reference model: an operation started at cycle T finishes at op_end=T+LAT-1.
    int          cyc = 0;
    int          op_end[2] = '{-1, -1};
    logic [31:0] m_scnt[2] = '{0, 0};
    logic [31:0] m_fcnt[2] = '{0, 0};
    int          mul_lat[2] = '{2, 1};
    int          div_lat[2] = '{33, 3};
    logic [31:0] cnt_max[2] = '{32'hFFFF_FFFF, 32'd15};
    logic [5:0]  last_a;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Packed as {pc_hold, if_id_hold, if_id_flush, id_ex_stall, md_busy, md_done}.
    function automatic logic [5:0] act_ctrl(input int i);
        if (i == 0) return {a_pch, a_ifh, a_ifl, a_stl, a_bsy, a_dne};
        return {b_pch, b_ifh, b_ifl, b_stl, b_bsy, b_dne};
    endfunction

    function automatic logic [31:0] act_cnt(input int i, input bit flush);
        if (i == 0) return flush ? a_fcnt : a_scnt;
        return flush ? 32'(b_fcnt) : 32'(b_scnt);
    endfunction

    function automatic bit ref_lu();
        return ex_dm_re && ex_rf_we && ex_rf_dst_addr != 0 &&
               ((id_rf_re0 && id_rf_p0_addr == ex_rf_dst_addr) ||
                (id_rf_re1 && id_rf_p1_addr == ex_rf_dst_addr));
    endfunction

    task automatic model_eval(input int i, output logic [5:0] e, output int new_end);
        int lat;
        lat = ex_div ? div_lat[i] : mul_lat[i];
        e = '0;
        new_end = -1;
        if (op_end[i] >= cyc) begin
            e[1] = 1'b1;
            e[0] = (cyc == op_end[i]);
            if (cyc < op_end[i]) e[5:2] = 4'b1101;
        end else if (ex_take) begin
            e[3:2] = 2'b11;
        end else if (ex_mul_div && lat > 1) begin
            e[5:2] = 4'b1101;
            new_end = cyc + lat - 1;
        end else if (ref_lu()) begin
            e[5:2] = 4'b1101;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            op_end[i] = -1;
            m_scnt[i] = 0;
            m_fcnt[i] = 0;
        end
    endtask

    // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        logic [5:0] e[2];
        int         ne[2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            model_eval(i, e[i], ne[i]);
            chk($sformatf("ctrl%0d", i), 32'(act_ctrl(i)), 32'(e[i]));
            chk($sformatf("stall_cnt%0d", i), act_cnt(i, 1'b0), m_scnt[i]);
            chk($sformatf("flush_cnt%0d", i), act_cnt(i, 1'b1), m_fcnt[i]);
        end
        last_a = act_ctrl(0);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (ne[i] >= 0) op_end[i] = ne[i];
            if (perf_clr) begin
                m_scnt[i] = 0;
                m_fcnt[i] = 0;
            end else begin
                if (e[i][5] && m_scnt[i] != cnt_max[i]) m_scnt[i]++;
                if (e[i][3] && m_fcnt[i] != cnt_max[i]) m_fcnt[i]++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic clear_in();
        {id_rf_p0_addr, id_rf_p1_addr, ex_rf_dst_addr} = '0;
        {id_rf_re0, id_rf_re1, ex_rf_we, ex_dm_re, ex_mul_div, ex_div, ex_take, perf_clr} = '0;
    endtask

    task automatic set_lu(input logic [4:0] dst, input logic [4:0] src);
        ex_dm_re = 1; ex_rf_we = 1; ex_rf_dst_addr = dst;
        id_rf_re0 = 1; id_rf_p0_addr = src;
    endtask

    task automatic pulse_reset();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        cyc++;
        #2;
        rst_n = 1;
    endtask

    typedef struct {
        logic       dm_re, we, re0, re1, take;
        logic [4:0] dst, p0, p1;
        logic [5:0] exp;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [31:0] s0, f0;
        int          holds, done_at;

        vt[0] = '{0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  6'b000000};
        vt[1] = '{1, 1, 1, 0, 0, 5'd5,  5'd5,  5'd0,  6'b110100};
        vt[2] = '{1, 1, 1, 0, 0, 5'd0,  5'd0,  5'd0,  6'b000000};
        vt[3] = '{1, 1, 0, 0, 0, 5'd5,  5'd5,  5'd0,  6'b000000};
        vt[4] = '{1, 1, 0, 1, 0, 5'd7,  5'd0,  5'd7,  6'b110100};
        vt[5] = '{1, 0, 0, 1, 0, 5'd7,  5'd0,  5'd7,  6'b000000};
        vt[6] = '{0, 1, 1, 1, 0, 5'd7,  5'd7,  5'd7,  6'b000000};
        vt[7] = '{1, 1, 1, 0, 1, 5'd9,  5'd9,  5'd0,  6'b001100};
        vt[8] = '{0, 0, 0, 0, 1, 5'd0,  5'd0,  5'd0,  6'b001100};
        vt[9] = '{1, 1, 1, 1, 0, 5'd31, 5'd30, 5'd31, 6'b110100};

        // Reset state.
        #12;
        chk("rst_ctrl_a", 32'(act_ctrl(0)), 0);
        chk("rst_ctrl_b", 32'(act_ctrl(1)), 0);
        chk("rst_scnt_a", a_scnt, 0);
        chk("rst_fcnt_b", 32'(b_fcnt), 0);
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1;

        // Directed combinational vectors from IDLE.
        for (int k = 0; k < 10; k++) begin
            clear_in();
            ex_dm_re = vt[k].dm_re; ex_rf_we = vt[k].we; ex_take = vt[k].take;
            id_rf_re0 = vt[k].re0; id_rf_re1 = vt[k].re1;
            ex_rf_dst_addr = vt[k].dst; id_rf_p0_addr = vt[k].p0; id_rf_p1_addr = vt[k].p1;
            tick();
            chk($sformatf("vec%0d", k), 32'(last_a), 32'(vt[k].exp));
        end
        clear_in();
        tick();
        chk("vec_stall_total", a_scnt, 3);

        // Flush beats load-use: flush counted, stall not.
        s0 = a_scnt; f0 = a_fcnt;
        set_lu(5'd4, 5'd4); ex_take = 1;
        tick();
        clear_in();
        tick();
        chk("take_flush_inc", a_fcnt, f0 + 1);
        chk("take_stall_same", a_scnt, s0);

        // DIV on instance A: 32 holds, done at T+32.
        s0 = a_scnt; holds = 0; done_at = -1;
        ex_mul_div = 1; ex_div = 1;
        for (int k = 0; k < 36; k++) begin
            tick();
            clear_in();
            if (last_a[5]) holds++;
            if (last_a[0]) done_at = k;
        end
        chk("div_holds", 32'(holds), 32);
        chk("div_done_at", 32'(done_at), 32);
        chk("div_stall_cnt", a_scnt - s0, 32);

        // MUL on A: one hold, done at T+1; on B (LAT=1): nothing.
        ex_mul_div = 1;
        tick();
        chk("mul_hold_T", 32'(last_a), 32'b110100);
        clear_in();
        tick();
        chk("mul_done_T1", 32'(last_a), 32'b000011);
        tick();

        // Reset in the middle of a DIV.
        ex_mul_div = 1; ex_div = 1;
        tick();
        clear_in();
        for (int k = 0; k < 9; k++) tick();
        rst_n = 0;
        #2;
        chk("mid_rst_busy", 32'(a_bsy), 0);
        chk("mid_rst_done", 32'(a_dne), 0);
        chk("mid_rst_scnt", a_scnt, 0);
        pulse_reset();
        ex_mul_div = 1;
        tick();
        clear_in();
        tick();
        chk("post_rst_mul_done", 32'(last_a[0]), 1);
        for (int k = 0; k < 30; k++) tick();

        // Saturation on the 4-bit instance, then clear beating a hazard.
        pulse_reset();
        for (int k = 0; k < 20; k++) begin
            set_lu(5'd3, 5'd3);
            tick();
        end
        clear_in();
        tick();
        chk("sat_b_15", 32'(b_scnt), 15);
        chk("sat_a_20", a_scnt, 20);
        set_lu(5'd3, 5'd3); perf_clr = 1;
        tick();
        clear_in();
        tick();
        chk("clr_b", 32'(b_scnt), 0);
        chk("clr_a", a_scnt, 0);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            ex_dm_re = 1'($urandom); ex_rf_we = 1'($urandom);
            ex_rf_dst_addr = 5'($urandom_range(0, 3));
            id_rf_p0_addr = 5'($urandom_range(0, 3));
            id_rf_p1_addr = 5'($urandom_range(0, 3));
            id_rf_re0 = 1'($urandom); id_rf_re1 = 1'($urandom);
            ex_take = ($urandom_range(0, 5) == 0);
            ex_mul_div = ($urandom_range(0, 7) == 0);
            ex_div = ($urandom_range(0, 3) == 0);
            perf_clr = ($urandom_range(0, 29) == 0);
            tick();
        end
        clear_in();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
